// File: rtl/axil_bk_pkg.sv
// rtl/axil_bk_pkg.sv - shared constants, types and helpers for the backend register bank
package axil_bk_pkg;
    localparam int REG_CTRL       = 0;
    localparam int REG_STATUS     = 1;
    localparam int REG_SCRATCH    = 2;
    localparam int REG_CYCLE      = 3;
    localparam int STATUS_OVF_BIT = 8;

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } req_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        return r;
    endfunction
endpackage

// File: rtl/axil_bk_regs.sv
// rtl/axil_bk_regs.sv - register storage, byte-strobe merge, sticky W1C status and cycle counter
module axil_bk_regs import axil_bk_pkg::*; #(
    parameter int NREG = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  logic [$clog2(NREG)-1:0]   widx_i,
    input  logic [31:0]               wdata_i,
    input  logic [3:0]                wstrb_i,
    input  logic [$clog2(NREG)-1:0]   ridx_i,
    output logic [31:0]               rdata_o,
    input  logic [7:0]                sts_set_i,
    input  logic                      ovf_set_i,
    output logic                      ctrl0_o
);
    localparam int IDX_W = $clog2(NREG);

    logic [31:0] mem_q [NREG];
    logic [8:0]  status_q, status_d;
    logic [8:0]  status_clr;
    logic [31:0] cycle_q;

    assign status_clr = {wstrb_i[1] & wdata_i[STATUS_OVF_BIT], wstrb_i[0] ? wdata_i[7:0] : 8'h00};

    // Set pulses are OR-ed in after the clear so a same-cycle set wins.
    always_comb begin
        status_d = status_q;
        if (we_i && widx_i == IDX_W'(REG_STATUS))
            status_d = status_q & ~status_clr;
        status_d = status_d | {ovf_set_i, sts_set_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
            status_q <= '0;
            cycle_q  <= '0;
        end else begin
            status_q <= status_d;
            cycle_q  <= cycle_q + 32'd1;
            if (we_i && widx_i != IDX_W'(REG_STATUS) && widx_i != IDX_W'(REG_CYCLE))
                mem_q[widx_i] <= strb_merge(mem_q[widx_i], wdata_i, wstrb_i);
        end
    end

    always_comb begin
        rdata_o = mem_q[ridx_i];
        if (ridx_i == IDX_W'(REG_STATUS))
            rdata_o = {23'd0, status_q};
        else if (ridx_i == IDX_W'(REG_CYCLE))
            rdata_o = cycle_q;
    end

    assign ctrl0_o = mem_q[REG_CTRL][0];
endmodule

// File: rtl/axil_bk_regfile.sv
// rtl/axil_bk_regfile.sv - backend register bank sequencer with one-deep pending slots per request type
module axil_bk_regfile import axil_bk_pkg::*; #(
    parameter int ADDR_W = 12,
    parameter int NREG   = 16,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              bk_wstart,
    input  logic [ADDR_W-1:0] bk_waddr,
    input  logic [31:0]       bk_wdata,
    input  logic [3:0]        bk_wstrb,
    output logic              bk_wdone,
    input  logic              bk_rstart,
    input  logic [ADDR_W-1:0] bk_raddr,
    output logic [31:0]       bk_rdata,
    output logic              bk_rdone,
    input  logic [7:0]        sts_set,
    output logic              cc_aa_enable,
    output logic              busy
);
    localparam int IDX_W = $clog2(NREG);

    state_e      state_q;
    logic [2:0]  cnt_q;
    req_t        wpend_q, rpend_q;
    logic        wpend_vld_q, rpend_vld_q;
    logic        wdone_q, rdone_q;
    logic [31:0] rdata_q, rbuf_q;

    req_t        win, rin, wreq, rreq;
    logic        idle, launch_wp, launch_rp, launch_wn, launch_rn, launch_w, launch_r;
    logic        cap_w, cap_r, ovf_w, ovf_r;
    logic        w_oor, r_oor;
    logic [31:0] reg_rdata, snap;
    logic        unused_bits;

    assign win = '{addr: 32'(bk_waddr), data: bk_wdata, strb: bk_wstrb};
    assign rin = '{addr: 32'(bk_raddr), data: 32'd0, strb: 4'd0};

    // Launch priority in IDLE: pending write, pending read, new write, new read.
    assign idle      = (state_q == IDLE);
    assign launch_wp = idle & wpend_vld_q;
    assign launch_rp = idle & ~wpend_vld_q & rpend_vld_q;
    assign launch_wn = idle & ~wpend_vld_q & ~rpend_vld_q & bk_wstart;
    assign launch_rn = idle & ~wpend_vld_q & ~rpend_vld_q & ~bk_wstart & bk_rstart;
    assign launch_w  = launch_wp | launch_wn;
    assign launch_r  = launch_rp | launch_rn;

    assign cap_w = bk_wstart & ~launch_wn & ~wpend_vld_q;
    assign ovf_w = bk_wstart & ~launch_wn &  wpend_vld_q;
    assign cap_r = bk_rstart & ~launch_rn & ~rpend_vld_q;
    assign ovf_r = bk_rstart & ~launch_rn &  rpend_vld_q;

    assign wreq  = wpend_vld_q ? wpend_q : win;
    assign rreq  = rpend_vld_q ? rpend_q : rin;
    assign w_oor = |wreq.addr[31:IDX_W+2];
    assign r_oor = |rreq.addr[31:IDX_W+2];
    assign snap  = r_oor ? 32'd0 : reg_rdata;

    assign unused_bits = ^{wreq.addr[1:0], rreq.addr[1:0], rreq.data, rreq.strb};

    axil_bk_regs #(.NREG(NREG)) u_regs (
        .clk       (axi_aclk),
        .rst       (axi_areset),
        .we_i      (launch_w & ~w_oor),
        .widx_i    (wreq.addr[IDX_W+1:2]),
        .wdata_i   (wreq.data),
        .wstrb_i   (wreq.strb),
        .ridx_i    (rreq.addr[IDX_W+1:2]),
        .rdata_o   (reg_rdata),
        .sts_set_i (sts_set),
        .ovf_set_i (ovf_w | ovf_r),
        .ctrl0_o   (cc_aa_enable)
    );

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wpend_q     <= '0;
            rpend_q     <= '0;
            wpend_vld_q <= 1'b0;
            rpend_vld_q <= 1'b0;
            wdone_q     <= 1'b0;
            rdone_q     <= 1'b0;
            rdata_q     <= '0;
            rbuf_q      <= '0;
        end else begin
            wdone_q <= 1'b0;
            rdone_q <= 1'b0;
            if (cap_w) begin
                wpend_q     <= win;
                wpend_vld_q <= 1'b1;
            end
            if (cap_r) begin
                rpend_q     <= rin;
                rpend_vld_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (launch_w) begin
                        state_q <= WR;
                        cnt_q   <= 3'(WR_LAT - 1);
                        wdone_q <= (WR_LAT == 1);
                        if (launch_wp) wpend_vld_q <= 1'b0;
                    end else if (launch_r) begin
                        state_q <= RD;
                        cnt_q   <= 3'(RD_LAT - 1);
                        rbuf_q  <= snap;
                        if (RD_LAT == 1) begin
                            rdone_q <= 1'b1;
                            rdata_q <= snap;
                        end
                        if (launch_rp) rpend_vld_q <= 1'b0;
                    end
                end
                // The done pulse occupies the final cycle of each state.
                WR: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q - 3'd1;
                        wdone_q <= (cnt_q == 3'd1);
                    end
                end
                RD: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            rdone_q <= 1'b1;
                            rdata_q <= rbuf_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bk_wdone = wdone_q;
    assign bk_rdone = rdone_q;
    assign bk_rdata = rdata_q;
    assign busy     = ~idle | wpend_vld_q | rpend_vld_q;
endmodule
